multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel down-counting timer for the Pokémon Mini system bus. It is the generalised successor to the fixed 2-channel/16-bit system timer. It provides NUM_CH independent channels with the following features:
- configurable width and per-channel prescaler source;
- one-shot or auto-reload mode;
- atomic count readback;
- per-channel underflow and compare interrupts.

It sits on the CPU register bus next to the IRQ controller, which consumes `irqs`.

## Interface
- NUM_CH, 4: number of channels (1..8).
- WIDTH, 16: counter width in bits (1..16); bits at or above WIDTH read 0 and ignore writes.
- BASE_ADDR, 24'h2040: address of channel 0; channel c occupies BASE_ADDR+8c .. +8c+7.
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-low reset.
- rt_ce  input  1  one-cycle pulse per 32768 Hz real-time-clock period, synchronous to clk.
- bus_write  input  1  write strobe for bus_address_in/bus_data_in.
- bus_read  input  1  read strobe; needed for the snapshot side effect.
- bus_address_in  input  24  byte address.
- bus_data_in  input  8  write data.
- bus_data_out  output  8  read data; combinational; 0 outside the mapped range.
- irqs  output  2*NUM_CH  registered one-cycle pulses; bit 2c = channel c underflow, bit 2c+1 = channel c compare match.

## Operation
Per-channel register offsets:
- +0 CTRL
  - b0 EN.
  - b1 RELOAD: write-only strobe, reads 0.
  - b2 ONESHOT.
  - b3 SRC: 0 = clk, 1 = rt_ce.
  - b4 CASC: see Configuration.
  - b7:5 PSEL.
- +1 STAT
  - b0 UF, b1 CMP: sticky flags; writing 1 clears the flag.
- +2/+3 PRESET low/high.
- +4/+5 COMPARE low/high.
- +6/+7 COUNT low/high: read-only.

Prescalers:
- One shared 14-bit clk prescaler and one shared 7-bit rt prescaler, both free-running from reset.
- rt prescaler advances only on rt_ce.
- Channel tick, SRC=0: clk prescaler low 2·PSEL bits all ones. PSEL=0 ticks every cycle; period is 4^PSEL cycles.
- Channel tick, SRC=1: rt_ce high and rt prescaler low PSEL bits all ones; period is 2^PSEL rt_ce pulses.

On a tick while EN=1:
- COUNT==0: COUNT←PRESET, pulse irqs[2c], set UF. If ONESHOT=1, EN←0.
- Otherwise: COUNT←COUNT−1. If COUNT−1 == COMPARE, pulse irqs[2c+1] and set CMP.
- Arithmetic is modulo 2^WIDTH. COMPARE ≥ 2^WIDTH never matches.

RELOAD strobe: COUNT←PRESET regardless of EN, with no interrupt. PRESET writes never touch COUNT directly.

Atomic read:
- A bus_read of +6 returns COUNT[7:0] and latches COUNT[15:8] into a per-channel shadow.
- Reading +7 returns the shadow.
- A +7 read without a prior +6 returns the shadow value from reset (0).

## Timing
- Register write takes effect at the posedge on which bus_write is sampled; the new value is visible to a read on the next cycle.
- Tick-to-COUNT-update: 1 cycle. irqs pulse and flag set occur on the same edge as the COUNT update.
- Reset (reset=0 at posedge): all CTRL/STAT/PRESET/COMPARE/COUNT/shadow registers and prescalers → 0; irqs → 0. An in-flight count is abandoned.
- Simultaneous tick and RELOAD write: reload wins, no interrupt.
- Tick and CTRL write clearing EN in the same cycle: the tick is ignored.
- Flag set and write-1-clear in the same cycle: set wins.
- Underflow in ONESHOT with an EN=1 write in the same cycle: the write wins and EN stays 1.
- PRESET=0, auto-reload, PSEL=0, SRC=0: underflow pulse every cycle.

## Configuration
- MULTI_TIMER_CASCADE_EN defined:
  - For channel c>0, CASC=1 replaces the prescaler tick with channel c−1's underflow event from the same cycle, so the chain has zero added latency.
  - CASC on channel 0 has no effect.
- Macro undefined: CASC reads 0, writes to it are ignored, and no inter-channel paths are built.

## Test plan
- Reset=0 for 2 cycles, then read all 8·NUM_CH addresses → every byte 0, irqs 0.
- Channel 0: PRESET=3, SRC=0, PSEL=0, EN=1 → COUNT 3,2,1,0 on successive cycles, then irqs[0] pulses while COUNT→3; UF=1; period is 4 cycles.
- Channel 1: ONESHOT=1, PRESET=2, COMPARE=1 → irqs[3] when COUNT reaches 1, irqs[2] once, then EN reads 0 and COUNT holds at 2.
- Channel 2: SRC=1, PSEL=2, PRESET=0, EN=1, rt_ce every 10 cycles → underflow on every 4th rt_ce pulse.
- COUNT=16'h0100 decrementing each cycle: read +6 (returns 8'h00, or the current low byte), then +7 after one tick → returns 8'h01 (the snapshot), not 8'h00.
- With MULTI_TIMER_CASCADE_EN: ch0 PRESET=1, ch1 CASC=1, PRESET=2 → ch1 underflows once every 6 clk cycles. Without the macro, CTRL b4 reads 0.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH down-counting timer channels with shared prescalers, compare match and atomic COUNT readback.
// Define MULTI_TIMER_CASCADE_EN to let channel c>0 count channel c-1 underflows (CTRL.CASC).
module multi_timer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h2040
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rt_ce,
    input  logic                  bus_write,
    input  logic                  bus_read,
    input  logic [23:0]           bus_address_in,
    input  logic [7:0]            bus_data_in,
    output logic [7:0]            bus_data_out,
    output logic [2*NUM_CH-1:0]   irqs
);

    localparam logic [15:0] WMASK = 16'((32'd1 << WIDTH) - 32'd1);
    localparam logic [23:0] SPAN  = 24'(8 * NUM_CH);

    logic [13:0] clk_pre;
    logic [6:0]  rt_pre;

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] oneshot;
    logic [NUM_CH-1:0] src;
    logic [NUM_CH-1:0] uf;
    logic [NUM_CH-1:0] cmp;
    logic [NUM_CH-1:0] casc_rd;
    logic [2:0]        psel    [NUM_CH];
    logic [15:0]       preset  [NUM_CH];
    logic [15:0]       compare [NUM_CH];
    logic [15:0]       count   [NUM_CH];
    logic [7:0]        shadow  [NUM_CH];
`ifdef MULTI_TIMER_CASCADE_EN
    logic [NUM_CH-1:0] casc;
`endif

    logic [23:0]       off;
    logic              in_range;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_stat;
    logic [NUM_CH-1:0] rd_cnt_lo;
    logic [NUM_CH-1:0] reload;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] live;
    logic [NUM_CH-1:0] uf_ev;
    logic [NUM_CH-1:0] cmp_ev;

    function automatic logic clk_tick(input logic [13:0] pre, input logic [2:0] p);
        logic [13:0] m;
        m = ~(14'h3fff << {p, 1'b0});
        return (pre & m) == m;
    endfunction

    function automatic logic rt_tick(input logic [6:0] pre, input logic [2:0] p);
        logic [6:0] m;
        m = ~(7'h7f << p);
        return (pre & m) == m;
    endfunction

    assign off      = bus_address_in - BASE_ADDR;
    assign in_range = (bus_address_in >= BASE_ADDR) && (off < SPAN);

`ifdef MULTI_TIMER_CASCADE_EN
    assign casc_rd = casc;
`else
    assign casc_rd = '0;
`endif

    // Channels are evaluated in index order so a cascaded channel sees the
    // underflow of its predecessor from the same cycle.
    always_comb begin
        ch_hit    = '0;
        wr_ctrl   = '0;
        wr_stat   = '0;
        rd_cnt_lo = '0;
        reload    = '0;
        tick      = '0;
        live      = '0;
        uf_ev     = '0;
        cmp_ev    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_hit[c]    = in_range && (off[5:3] == 3'(c));
            wr_ctrl[c]   = bus_write && ch_hit[c] && (off[2:0] == 3'd0);
            wr_stat[c]   = bus_write && ch_hit[c] && (off[2:0] == 3'd1);
            rd_cnt_lo[c] = bus_read && ch_hit[c] && (off[2:0] == 3'd6);
            reload[c]    = wr_ctrl[c] && bus_data_in[1];
            tick[c]      = src[c] ? (rt_ce && rt_tick(rt_pre, psel[c]))
                                  : clk_tick(clk_pre, psel[c]);
`ifdef MULTI_TIMER_CASCADE_EN
            if (c > 0 && casc[c])
                tick[c] = uf_ev[c-1];
`endif
            live[c]   = tick[c] && en[c] && !(wr_ctrl[c] && !bus_data_in[0]) && !reload[c];
            uf_ev[c]  = live[c] && (count[c] == 16'h0000);
            cmp_ev[c] = live[c] && (count[c] != 16'h0000) &&
                        (((count[c] - 16'd1) & WMASK) == compare[c]);
        end
    end

    always_comb begin
        bus_data_out = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) begin
                case (off[2:0])
                    3'd0: bus_data_out = {psel[c], casc_rd[c], src[c], oneshot[c], 1'b0, en[c]};
                    3'd1: bus_data_out = {6'b0, cmp[c], uf[c]};
                    3'd2: bus_data_out = preset[c][7:0];
                    3'd3: bus_data_out = preset[c][15:8];
                    3'd4: bus_data_out = compare[c][7:0];
                    3'd5: bus_data_out = compare[c][15:8];
                    3'd6: bus_data_out = count[c][7:0];
                    3'd7: bus_data_out = shadow[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_pre <= '0;
            rt_pre  <= '0;
            irqs    <= '0;
            en      <= '0;
            oneshot <= '0;
            src     <= '0;
            uf      <= '0;
            cmp     <= '0;
`ifdef MULTI_TIMER_CASCADE_EN
            casc    <= '0;
`endif
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                psel[c]    <= '0;
                preset[c]  <= '0;
                compare[c] <= '0;
                count[c]   <= '0;
                shadow[c]  <= '0;
            end
        end else begin
            clk_pre <= clk_pre + 14'd1;
            if (rt_ce)
                rt_pre <= rt_pre + 7'd1;

            for (int unsigned c = 0; c < NUM_CH; c++) begin
                irqs[2*c]   <= uf_ev[c];
                irqs[2*c+1] <= cmp_ev[c];

                // A CTRL write overrides the one-shot auto-disable.
                if (wr_ctrl[c]) begin
                    en[c]      <= bus_data_in[0];
                    oneshot[c] <= bus_data_in[2];
                    src[c]     <= bus_data_in[3];
                    psel[c]    <= bus_data_in[7:5];
`ifdef MULTI_TIMER_CASCADE_EN
                    casc[c]    <= bus_data_in[4];
`endif
                end else if (uf_ev[c] && oneshot[c]) begin
                    en[c] <= 1'b0;
                end

                uf[c]  <= (uf[c]  && !(wr_stat[c] && bus_data_in[0])) || uf_ev[c];
                cmp[c] <= (cmp[c] && !(wr_stat[c] && bus_data_in[1])) || cmp_ev[c];

                if (bus_write && ch_hit[c]) begin
                    case (off[2:0])
                        3'd2:    preset[c][7:0]   <= bus_data_in & WMASK[7:0];
                        3'd3:    preset[c][15:8]  <= bus_data_in & WMASK[15:8];
                        3'd4:    compare[c][7:0]  <= bus_data_in & WMASK[7:0];
                        3'd5:    compare[c][15:8] <= bus_data_in & WMASK[15:8];
                        default: ;
                    endcase
                end

                if (reload[c] || uf_ev[c])
                    count[c] <= preset[c];
                else if (live[c])
                    count[c] <= (count[c] - 16'd1) & WMASK;

                if (rd_cnt_lo[c])
                    shadow[c] <= count[c][15:8];
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed, table-driven register checks plus hand-written timing sequences for multi_timer.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rt_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [7:0]  irqs;

    int errors = 0;
    int checks = 0;

    multi_timer #(.NUM_CH(4), .WIDTH(16), .BASE_ADDR(24'h2040)) dut (
        .clk           (clk),
        .reset         (reset),
        .rt_ce         (rt_ce),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .irqs          (irqs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [23:0] addr;
        logic [7:0]  val;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        cyc();
        bus_write      = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, output logic [7:0] d);
        bus_address_in = a;
        bus_read       = 1'b1;
        #1;
        d = bus_data_out;
        cyc();
        bus_read       = 1'b0;
    endtask

    task automatic peek(input logic [23:0] a, output logic [7:0] d);
        bus_address_in = a;
        #1;
        d = bus_data_out;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic [7:0] exp_cnt [6];
        logic [1:0] exp_irq [6];
        int         npulse;

        reset = 1'b0; rt_ce = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = '0; bus_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("reset irqs", {8'h00, irqs}, 16'h0000);
        for (int i = 0; i < 32; i++) begin
            peek(24'h2040 + 24'(i), v);
            chk($sformatf("reset byte %0h", 24'h2040 + 24'(i)), {8'h00, v}, 16'h0000);
        end

        // register access table on channel 3 (disabled, so nothing counts)
        vecs.push_back('{1'b0, 24'h2058, 8'hEC});
        vecs.push_back('{1'b1, 24'h2058, 8'hEC});
        vecs.push_back('{1'b0, 24'h2058, 8'hFE});
`ifdef MULTI_TIMER_CASCADE_EN
        vecs.push_back('{1'b1, 24'h2058, 8'hFC});
`else
        vecs.push_back('{1'b1, 24'h2058, 8'hEC});
`endif
        vecs.push_back('{1'b0, 24'h205A, 8'h34});
        vecs.push_back('{1'b0, 24'h205B, 8'h12});
        vecs.push_back('{1'b1, 24'h205A, 8'h34});
        vecs.push_back('{1'b1, 24'h205B, 8'h12});
        vecs.push_back('{1'b1, 24'h205E, 8'h00});
        vecs.push_back('{1'b0, 24'h205C, 8'hAB});
        vecs.push_back('{1'b0, 24'h205D, 8'hCD});
        vecs.push_back('{1'b1, 24'h205C, 8'hAB});
        vecs.push_back('{1'b1, 24'h205D, 8'hCD});
        vecs.push_back('{1'b0, 24'h2058, 8'h02});
        vecs.push_back('{1'b1, 24'h205F, 8'h00});
        vecs.push_back('{1'b1, 24'h205E, 8'h34});
        vecs.push_back('{1'b1, 24'h205F, 8'h12});
        vecs.push_back('{1'b0, 24'h205E, 8'hFF});
        vecs.push_back('{1'b1, 24'h205E, 8'h34});
        vecs.push_back('{1'b1, 24'h2059, 8'h00});
        vecs.push_back('{1'b1, 24'h203F, 8'h00});
        vecs.push_back('{1'b0, 24'h2060, 8'h55});
        vecs.push_back('{1'b1, 24'h2060, 8'h00});
        foreach (vecs[i]) begin
            if (vecs[i].is_rd) begin
                rd(vecs[i].addr, v);
                chk($sformatf("vec%0d rd %0h", i, vecs[i].addr), {8'h00, v}, {8'h00, vecs[i].val});
            end else begin
                wr(vecs[i].addr, vecs[i].val);
            end
        end

        // channel 0: PRESET=3 auto-reload, tick every cycle, COMPARE=0
        wr(24'h2042, 8'h03);
        wr(24'h2040, 8'h02);
        wr(24'h2040, 8'h01);
        exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2};
        exp_irq = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            peek(24'h2046, v);
            chk($sformatf("ch0 count t%0d", i), {8'h00, v}, {8'h00, exp_cnt[i]});
            chk($sformatf("ch0 irqs t%0d", i), {14'h0, irqs[1:0]}, {14'h0, exp_irq[i]});
            cyc();
        end
        wr(24'h2040, 8'h00);
        rd(24'h2041, v);  chk("ch0 stat", {8'h00, v}, 16'h0003);
        wr(24'h2041, 8'h01);
        rd(24'h2041, v);  chk("ch0 stat uf clr", {8'h00, v}, 16'h0002);
        wr(24'h2041, 8'h02);
        rd(24'h2041, v);  chk("ch0 stat cmp clr", {8'h00, v}, 16'h0000);

        // channel 0: PRESET=0 underflows every cycle; W1C/set, reload and disable races
        wr(24'h2042, 8'h00);
        wr(24'h2040, 8'h02);
        wr(24'h2040, 8'h01);
        chk("p0 irq before first tick", {15'h0, irqs[0]}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("p0 irq cycle %0d", i), {15'h0, irqs[0]}, 16'h0001);
        end
        wr(24'h2041, 8'h01);
        chk("p0 irq during w1c", {15'h0, irqs[0]}, 16'h0001);
        wr(24'h2040, 8'h03);
        chk("reload beats tick", {15'h0, irqs[0]}, 16'h0000);
        wr(24'h2040, 8'h00);
        chk("en clear drops tick", {15'h0, irqs[0]}, 16'h0000);
        rd(24'h2041, v);  chk("set beats w1c", {8'h00, v}, 16'h0001);
        wr(24'h2041, 8'h01);

        // channel 1: one-shot, PRESET=2, COMPARE=1
        wr(24'h204A, 8'h02);
        wr(24'h204C, 8'h01);
        wr(24'h2048, 8'h02);
        wr(24'h2048, 8'h05);
        exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2};
        exp_irq = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            peek(24'h204E, v);
            chk($sformatf("ch1 count t%0d", i), {8'h00, v}, {8'h00, exp_cnt[i]});
            chk($sformatf("ch1 irqs t%0d", i), {14'h0, irqs[3:2]}, {14'h0, exp_irq[i]});
            cyc();
        end
        rd(24'h2048, v);  chk("ch1 oneshot ctrl", {8'h00, v}, 16'h0004);
        rd(24'h2049, v);  chk("ch1 stat", {8'h00, v}, 16'h0003);
        wr(24'h2049, 8'h03);
        wr(24'h2048, 8'h06);
        wr(24'h2048, 8'h05);
        cyc();
        cyc();
        wr(24'h2048, 8'h05);
        chk("ch1 uf with en write", {15'h0, irqs[2]}, 16'h0001);
        rd(24'h2048, v);  chk("en write beats oneshot", {8'h00, v}, 16'h0005);
        peek(24'h204E, v); chk("ch1 keeps counting", {8'h00, v}, 16'h0001);
        wr(24'h2048, 8'h00);

        // channel 2: rt_ce source, PSEL=2, PRESET=0, rt_ce every 10 cycles
        wr(24'h2050, 8'h49);
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 9; j++) begin
                cyc();
                if (irqs[4]) npulse++;
            end
            rt_ce = 1'b1;
            cyc();
            rt_ce = 1'b0;
            chk($sformatf("ch2 rt pulse %0d", k), {15'h0, irqs[4]}, {15'h0, ((k % 4) == 3)});
        end
        chk("ch2 idle irqs", 16'(npulse), 16'd0);
        wr(24'h2050, 8'h00);

        // channel 3: atomic readback of a 16-bit count decrementing every cycle
        wr(24'h205A, 8'h00);
        wr(24'h205B, 8'h01);
        wr(24'h2058, 8'h02);
        wr(24'h2058, 8'h01);
        rd(24'h205E, v);  chk("atomic lo", {8'h00, v}, 16'h0000);
        rd(24'h205F, v);  chk("atomic hi shadow", {8'h00, v}, 16'h0001);
        rd(24'h205E, v);  chk("atomic lo 2", {8'h00, v}, 16'h00FE);
        rd(24'h205F, v);  chk("atomic hi 2", {8'h00, v}, 16'h0000);

        // reset while channel 3 is running
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("mid reset irqs", {8'h00, irqs}, 16'h0000);
        peek(24'h205E, v); chk("mid reset count", {8'h00, v}, 16'h0000);
        peek(24'h2058, v); chk("mid reset ctrl", {8'h00, v}, 16'h0000);
        peek(24'h205A, v); chk("mid reset preset", {8'h00, v}, 16'h0000);
        cyc();

`ifdef MULTI_TIMER_CASCADE_EN
        // ch1 counts ch0 underflows: ch0 period 2, ch1 PRESET=2 -> period 6
        wr(24'h2042, 8'h01);
        wr(24'h2040, 8'h02);
        wr(24'h204A, 8'h02);
        wr(24'h2048, 8'h12);
        wr(24'h2048, 8'h11);
        rd(24'h2048, v);  chk("casc ctrl", {8'h00, v}, 16'h0011);
        wr(24'h2040, 8'h01);
        for (int i = 1; i <= 14; i++) begin
            cyc();
            chk($sformatf("casc ch1 uf t%0d", i), {15'h0, irqs[2]}, {15'h0, ((i % 6) == 0)});
        end
`else
        wr(24'h2048, 8'h10);
        rd(24'h2048, v);  chk("casc bit reads 0", {8'h00, v}, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
